// File: rtl/duck_ctl_pkg.sv
// Shared screen geometry, duck FSM states and the wall-bounce step helper
// used by the duck motion controller.
package DH_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;
    localparam int GROUND_Y   = 600;
    localparam int DUCK_W     = 64;
    localparam int DUCK_H     = 64;

    localparam logic [10:0] XMAX = 11'(HOR_PIXELS - DUCK_W);
    localparam logic [10:0] YMAX = 11'(GROUND_Y - DUCK_H);

    typedef enum logic [2:0] {IDLE, FLY, HIT, FALL, ESCAPE} duck_state_t;

    typedef struct packed {
        logic [10:0] pos;
        logic        flip;
    } step_t;

    // One axis step against [0, lim]; the bound test precedes the arithmetic
    // so the result never wraps.
    function automatic step_t bounce_step(input logic [10:0] pos, input logic [10:0] spd,
                                          input logic [10:0] lim, input logic inc);
        step_t r;
        r.flip = 1'b0;
        if (inc) begin
            if ({1'b0, pos} + {1'b0, spd} > {1'b0, lim}) begin
                r.pos  = lim;
                r.flip = 1'b1;
            end else begin
                r.pos = pos + spd;
            end
        end else begin
            if (pos < spd) begin
                r.pos  = '0;
                r.flip = 1'b1;
            end else begin
                r.pos = pos - spd;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/duck_ctl_if.sv
// Game-side bus of the duck controller: frame/spawn/shot in, sprite state
// and outcome pulses out.
interface duck_ctl_if;
    logic        new_frame;
    logic        spawn;
    logic        shot_hit;
    logic [10:0] duck_x;
    logic [10:0] duck_y;
    logic        duck_show;
    logic        duck_hit;
    logic        duck_down;
    logic        duck_escaped;

    modport master (output new_frame, spawn, shot_hit,
                    input  duck_x, duck_y, duck_show, duck_hit, duck_down, duck_escaped);
    modport slave  (input  new_frame, spawn, shot_hit,
                    output duck_x, duck_y, duck_show, duck_hit, duck_down, duck_escaped);
endinterface

// File: rtl/duck_ctl_lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, stepping every clock.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value_o
);
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign value_o = lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end
endmodule

// File: rtl/duck_ctl.sv
// Duck flight / hit / fall / escape sequencer; moves the sprite once per frame
// and reports each duck's fate as one-cycle pulses.
module duck_ctl
    import DH_pkg::*;
#(
    parameter int unsigned  SPEED_X    = 3,
    parameter int unsigned  SPEED_Y    = 2,
    parameter int unsigned  FALL_SPEED = 4,
    parameter int unsigned  ESC_SPEED  = 4,
    parameter int unsigned  FLY_FRAMES = 600,
    parameter int unsigned  HIT_FRAMES = 30,
    parameter logic [15:0]  LFSR_SEED  = 16'hACE1
) (
    input logic       clk,
    input logic       rst,
    duck_ctl_if.slave bus
);
    localparam logic [10:0] SX       = 11'(SPEED_X);
    localparam logic [10:0] SY       = 11'(SPEED_Y);
    localparam logic [10:0] FS       = 11'(FALL_SPEED);
    localparam logic [10:0] ES       = 11'(ESC_SPEED);
    localparam logic [15:0] FLY_LAST = 16'(FLY_FRAMES - 1);
    localparam logic [15:0] HIT_LAST = 16'(HIT_FRAMES - 1);

    logic [15:0] lfsr;
    logic        unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .value_o(lfsr));
    assign unused_lfsr = ^lfsr[14:9];

    duck_state_t state_q, state_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic        dx_q, dx_d;   // 1 = moving right
    logic        dy_q, dy_d;   // 1 = moving down
    logic [15:0] cnt_q, cnt_d;
    logic        show_q, show_d, hit_q, hit_d, down_q, down_d, esc_q, esc_d;
    step_t       hs, vs;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        cnt_d   = cnt_q;
        down_d  = 1'b0;
        esc_d   = 1'b0;
        hs      = bounce_step(x_q, SX, XMAX, dx_q);
        vs      = bounce_step(y_q, SY, YMAX, dy_q);
        case (state_q)
            IDLE: if (bus.spawn) begin
                x_d     = {2'b00, lfsr[8:0]} + 11'd224;
                y_d     = YMAX;
                dy_d    = 1'b0;
                dx_d    = lfsr[15];
                cnt_d   = '0;
                state_d = FLY;
            end
            FLY: begin
                // A shot in the same cycle as a frame tick freezes the duck in place.
                if (bus.shot_hit) begin
                    cnt_d   = '0;
                    state_d = HIT;
                end else if (bus.new_frame) begin
                    x_d  = hs.pos;
                    y_d  = vs.pos;
                    dy_d = dy_q ^ vs.flip;
                    dx_d = dx_q ^ hs.flip ^ ((cnt_q[4:0] == 5'd31) & lfsr[0]);
                    if (cnt_q == FLY_LAST) begin
                        cnt_d   = '0;
                        state_d = ESCAPE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            HIT: if (bus.new_frame) begin
                if (cnt_q == HIT_LAST) begin
                    cnt_d   = '0;
                    state_d = FALL;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FALL: if (bus.new_frame) begin
                if ({1'b0, y_q} + {1'b0, FS} >= {1'b0, YMAX}) begin
                    y_d     = YMAX;
                    down_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    y_d = y_q + FS;
                end
            end
            ESCAPE: if (bus.new_frame) begin
                if (y_q < ES) begin
                    y_d     = '0;
                    esc_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    y_d = y_q - ES;
                end
            end
            default: state_d = IDLE;
        endcase
        show_d = (state_d != IDLE);
        hit_d  = (state_d == HIT) || (state_d == FALL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= 1'b0;
            dy_q    <= 1'b0;
            cnt_q   <= '0;
            show_q  <= 1'b0;
            hit_q   <= 1'b0;
            down_q  <= 1'b0;
            esc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            cnt_q   <= cnt_d;
            show_q  <= show_d;
            hit_q   <= hit_d;
            down_q  <= down_d;
            esc_q   <= esc_d;
        end
    end

    assign bus.duck_x       = x_q;
    assign bus.duck_y       = y_q;
    assign bus.duck_show    = show_q;
    assign bus.duck_hit     = hit_q;
    assign bus.duck_down    = down_q;
    assign bus.duck_escaped = esc_q;
endmodule

// File: doc/duck_ctl.md
# duck_ctl

Duck motion and life-cycle controller for Duck Hunt. It sits directly upstream of `draw_duck` and drives its `duck_x`, `duck_y`, `duck_show` and `duck_hit` inputs. Positions update once per frame on `new_frame` from `vga_timing`. The block owns the fly / hit / fall / escape sequence and reports the outcome of each duck to game logic as one-cycle pulses.

## Interface
Parameters:
- `SPEED_X`, 3: horizontal step in px per frame while flying.
- `SPEED_Y`, 2: vertical step in px per frame while flying.
- `FALL_SPEED`, 4: downward step in px per frame after a hit.
- `ESC_SPEED`, 4: upward step in px per frame while escaping.
- `FLY_FRAMES`, 600: frames of flight before the duck escapes.
- `HIT_FRAMES`, 30: frames the duck is frozen after a hit.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- `clk`  in  1  65 MHz pixel clock.
- `rst`  in  1  asynchronous, active-high reset.
- `new_frame`  in  1  one-cycle pulse at frame start.
- `spawn`  in  1  request a new duck; honoured only in IDLE.
- `shot_hit`  in  1  pulse from hit detection; honoured only in FLY.
- `duck_x`  out  11  top-left x of the duck.
- `duck_y`  out  11  top-left y of the duck.
- `duck_show`  out  1  duck is visible.
- `duck_hit`  out  1  duck has been shot (drives the hit sprite).
- `duck_down`  out  1  one-cycle pulse when a shot duck reaches the ground.
- `duck_escaped`  out  1  one-cycle pulse when the duck leaves through the top.

## Operation
- Limits: XMAX = HOR_PIXELS−DUCK_W = 960; YMAX = GROUND_Y−DUCK_H = 536.
- The 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) advances every clock.
- States: IDLE, FLY, HIT, FALL, ESCAPE.
- IDLE:
  - `duck_show`=0 and `duck_hit`=0.
  - On `spawn`: x = lfsr[8:0]+224; y = YMAX; dy = up; dx = right if lfsr[15] else left; frame counter cleared; go to FLY.
- FLY, on each `new_frame`:
  - Horizontal step: moving right, if x+SPEED_X > XMAX then x=XMAX and dx flips, else x+=SPEED_X. Moving left, if x < SPEED_X then x=0 and dx flips, else x−=SPEED_X.
  - Vertical step: same rule with SPEED_Y against the bounds 0 and YMAX.
  - Every 32nd frame (counter[4:0]==31), dx flips if lfsr[0]=1.
  - Counter increments. When the counter reaches FLY_FRAMES−1, go to ESCAPE.
- FLY, on `shot_hit` in any cycle: go to HIT, `duck_hit`=1, position frozen, counter cleared.
- HIT: position held. After HIT_FRAMES `new_frame` pulses, go to FALL.
- FALL, on each `new_frame`:
  - If y+FALL_SPEED ≥ YMAX: y=YMAX, pulse `duck_down`, go to IDLE.
  - Else y+=FALL_SPEED.
- ESCAPE (`duck_hit`=0), on each `new_frame`:
  - If y < ESC_SPEED: y=0, pulse `duck_escaped`, go to IDLE.
  - Else y−=ESC_SPEED.
- In all states except IDLE, `duck_show`=1.
- Arithmetic is 11-bit unsigned. Every bound check is done before the subtract, so there is never wrap-around.

## Timing
- All outputs are registered. A position change appears the cycle after the `new_frame` pulse and stays stable for the rest of the frame.
- `shot_hit` → `duck_hit` high: 1 cycle.
- Simultaneous `shot_hit` and flight timeout in the same cycle: hit wins.
- `spawn` outside IDLE is ignored. `shot_hit` outside FLY is ignored.
- `spawn` arriving in the same cycle as `new_frame`: spawn is taken; the first movement happens on the next `new_frame`.
- `duck_down` and `duck_escaped` are exactly 1 cycle wide and never overlap.
- Reset, including mid-flight, forces: state=IDLE, `duck_x`=0, `duck_y`=0, all flags and pulses 0, counter=0, lfsr=LFSR_SEED.

## Structure
- `DH_pkg` holds:
  - constants HOR_PIXELS=1024, VER_PIXELS=768, GROUND_Y=600, DUCK_W=64, DUCK_H=64;
  - `duck_state_t` enum {IDLE, FLY, HIT, FALL, ESCAPE}.
- One sub-module: `lfsr16`, with parameter SEED, ports clk/rst, output 16-bit value.
- FSM, position registers and frame counter live in `duck_ctl`.

## Test plan
- Reset mid-FLY: assert `rst` → outputs 0 immediately, state IDLE, no pulses.
- Spawn with lfsr=16'h8000: `spawn` pulse → next cycle `duck_show`=1, x=224, y=536; after the first `new_frame` x=227, y=534.
- Right-wall bounce: spawn at x=958 moving right → `new_frame` gives x=960; the next gives x=957.
- Hit then fall: `shot_hit` at y=500 → `duck_hit`=1 next cycle; x,y held for 30 frames; then y 504, 508, … until y=536 with a single `duck_down` pulse and `duck_show`=0.
- Escape: FLY_FRAMES=8, no shot → ESCAPE after 8 frames; y decreases by 4 per frame to 0; one `duck_escaped` pulse; back in IDLE.
- Simultaneity: `shot_hit` on the timeout `new_frame` → state HIT, no `duck_escaped`; `spawn` during FALL ignored.
